// File: rtl/median_pkg.sv
// Shared types and constants for the streaming 3x3 median filter.
package median_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned BORDER_REPLICATE = 0;
    localparam int unsigned BORDER_ZERO      = 1;

    // Per-pixel markers that travel alongside the median pipeline.
    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } side_t;

endpackage

// File: rtl/median9_sort.sv
// Three-stage pipelined exact median of nine: sort each column triple,
// then median of (max of lows, median of mids, min of highs).
module median9_sort #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [9*DATA_W-1:0]   win,
    output logic [DATA_W-1:0]     med
);

    function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] mn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    logic [DATA_W-1:0] lo_c [3];
    logic [DATA_W-1:0] md_c [3];
    logic [DATA_W-1:0] hi_c [3];
    logic [DATA_W-1:0] lo_q [3];
    logic [DATA_W-1:0] md_q [3];
    logic [DATA_W-1:0] hi_q [3];
    logic [DATA_W-1:0] lo_max_q;
    logic [DATA_W-1:0] md_med_q;
    logic [DATA_W-1:0] hi_min_q;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            lo_c[k] = mn(mn(win[(3*k+0)*DATA_W +: DATA_W], win[(3*k+1)*DATA_W +: DATA_W]),
                         win[(3*k+2)*DATA_W +: DATA_W]);
            hi_c[k] = mx(mx(win[(3*k+0)*DATA_W +: DATA_W], win[(3*k+1)*DATA_W +: DATA_W]),
                         win[(3*k+2)*DATA_W +: DATA_W]);
            md_c[k] = med3(win[(3*k+0)*DATA_W +: DATA_W], win[(3*k+1)*DATA_W +: DATA_W],
                           win[(3*k+2)*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                lo_q[k] <= '0;
                md_q[k] <= '0;
                hi_q[k] <= '0;
            end
            lo_max_q <= '0;
            md_med_q <= '0;
            hi_min_q <= '0;
            med      <= '0;
        end else if (en) begin
            for (int k = 0; k < 3; k++) begin
                lo_q[k] <= lo_c[k];
                md_q[k] <= md_c[k];
                hi_q[k] <= hi_c[k];
            end
            lo_max_q <= mx(mx(lo_q[0], lo_q[1]), lo_q[2]);
            md_med_q <= med3(md_q[0], md_q[1], md_q[2]);
            hi_min_q <= mn(mn(hi_q[0], hi_q[1]), hi_q[2]);
            med      <= med3(lo_max_q, md_med_q, hi_min_q);
        end
    end

endmodule

// File: rtl/streaming_median3x3.sv
// Streaming 3x3 median filter over a raster frame with two line buffers,
// edge handling by replicate or zero fill, and ready/valid on both sides.
module streaming_median3x3
    import median_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          IMG_W       = 554,
    parameter int          IMG_H       = 430,
    parameter int unsigned BORDER_MODE = BORDER_REPLICATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW    = 3 * DATA_W;

    state_t state, state_next;

    logic [COL_W-1:0] in_col, out_col;
    logic [ROW_W-1:0] in_row, out_row;
    logic             en, flush_issued;
    logic             adv, step, emit;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [CW-1:0]     sr1, sr2, col_new, col_left, col_right;
    logic [3*CW-1:0]   win_q;
    logic [DATA_W-1:0] lb0_rd, lb1_rd, new_pix;
    logic              top_b, bot_b;

    logic  v_win, v1, v2;
    side_t sd_d, sd_win, sd1, sd2, sd3;

    function automatic logic [DATA_W-1:0] bord(input logic [DATA_W-1:0] x);
        return (BORDER_MODE == BORDER_ZERO) ? '0 : x;
    endfunction

    function automatic logic [CW-1:0] bord_col(input logic [CW-1:0] x);
        return (BORDER_MODE == BORDER_ZERO) ? '0 : x;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FILL;
        else     state <= state_next;
    end

    // Handshake, step qualification and frame sequencing.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        step       = 1'b0;
        emit       = 1'b0;
        adv        = !m_valid || m_ready;
        case (state)
            ST_FILL: begin
                s_ready = en && adv;
                step    = s_ready && s_valid;
                if (step && in_row == ROW_W'(1) && in_col == '0)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                s_ready = en && adv;
                step    = s_ready && s_valid;
                emit    = step;
                if (step && in_row == ROW_W'(IMG_H - 1) && in_col == COL_W'(IMG_W - 1))
                    state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                step = adv && !flush_issued;
                emit = step;
                if (m_valid && m_ready && sd3.last)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_FILL;
            default: state_next = ST_FILL;
        endcase
    end

    // Column assembly: rows of the new column are clamped by the row of its centre.
    always_comb begin
        lb0_rd    = lb0[in_col];
        lb1_rd    = lb1[in_col];
        new_pix   = (state == ST_FLUSH) ? '0 : s_data;
        top_b     = (state == ST_FLUSH) ? (IMG_H == 1) : (in_row == ROW_W'(1));
        bot_b     = (state == ST_FLUSH);
        col_new   = {top_b ? bord(lb0_rd) : lb1_rd, lb0_rd, bot_b ? bord(lb0_rd) : new_pix};
        col_left  = (out_col == '0) ? bord_col(sr1) : sr2;
        col_right = (out_col == COL_W'(IMG_W - 1)) ? bord_col(sr1) : col_new;
        sd_d.sof  = (out_col == '0) && (out_row == '0);
        sd_d.eol  = (out_col == COL_W'(IMG_W - 1));
        sd_d.last = (out_col == COL_W'(IMG_W - 1)) && (out_row == ROW_W'(IMG_H - 1));
    end

    // Pixel storage; never reset, only read after being written this frame.
    always_ff @(posedge clk) begin
        if (step) begin
            lb0[in_col] <= new_pix;
            lb1[in_col] <= lb0_rd;
            sr2         <= sr1;
            sr1         <= col_new;
        end
        if (emit)
            win_q <= {col_right, sr1, col_left};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en           <= 1'b0;
            in_col       <= '0;
            in_row       <= '0;
            out_col      <= '0;
            out_row      <= '0;
            flush_issued <= 1'b0;
            frame_done   <= 1'b0;
            v_win        <= 1'b0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            m_valid      <= 1'b0;
            sd_win       <= '0;
            sd1          <= '0;
            sd2          <= '0;
            sd3          <= '0;
        end else begin
            en         <= 1'b1;
            frame_done <= (state_next == ST_DONE);
            if (step) begin
                in_col <= (in_col == COL_W'(IMG_W - 1)) ? '0 : in_col + COL_W'(1);
                if (state != ST_FLUSH && in_col == COL_W'(IMG_W - 1))
                    in_row <= (in_row == ROW_W'(IMG_H - 1)) ? '0 : in_row + ROW_W'(1);
            end
            if (emit) begin
                out_col <= (out_col == COL_W'(IMG_W - 1)) ? '0 : out_col + COL_W'(1);
                if (out_col == COL_W'(IMG_W - 1))
                    out_row <= (out_row == ROW_W'(IMG_H - 1)) ? '0 : out_row + ROW_W'(1);
                if (state == ST_FLUSH && sd_d.last)
                    flush_issued <= 1'b1;
            end
            if (state == ST_DONE) begin
                in_col       <= '0;
                flush_issued <= 1'b0;
            end
            if (adv) begin
                v_win   <= emit;
                v1      <= v_win;
                v2      <= v1;
                m_valid <= v2;
                if (emit) sd_win <= sd_d;
                sd1 <= sd_win;
                sd2 <= sd1;
                sd3 <= sd2;
            end
        end
    end

    median9_sort #(.DATA_W(DATA_W)) u_sort (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .win (win_q),
        .med (m_data)
    );

    assign m_sof = sd3.sof;
    assign m_eol = sd3.eol;

endmodule

// File: tb/tb_streaming_median3x3.sv
// Directed bench for streaming_median3x3 on a 4x3 frame, replicate and zero borders.
module tb_streaming_median3x3;
    import median_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       m_ready = 1'b1;
    logic       s_ready, m_valid, m_sof, m_eol, frame_done;
    logic [7:0] m_data;
    logic       s_ready_z, m_valid_z, m_sof_z, m_eol_z, frame_done_z;
    logic [7:0] m_data_z;

    always #5 clk = ~clk;

    streaming_median3x3 #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(BORDER_REPLICATE)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .frame_done(frame_done));

    streaming_median3x3 #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(BORDER_ZERO)) dut_z (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_z), .s_data(s_data),
        .m_valid(m_valid_z), .m_ready(m_ready), .m_data(m_data_z), .m_sof(m_sof_z), .m_eol(m_eol_z),
        .frame_done(frame_done_z));

    typedef struct {
        int               kind;
        bit               stall;
        logic [11:0][7:0] exp_rep;
        logic [11:0][7:0] exp_zero;
        bit               chk_zero;
    } vec_t;

    vec_t tbl [4];
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] cap_d [64];
    logic [7:0] cap_z [64];
    bit         cap_sof [64];
    bit         cap_eol [64];
    int         cap_n = 0;
    int         done_n = 0;
    bit         bp_mode = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int idx);
        case (kind)
            0:       return 8'd7;
            1:       return (idx == 5) ? 8'd255 : 8'd0;
            2:       return 8'(idx);
            default: return 8'd9;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (cap_n < 64) begin
                    cap_d[cap_n]   = m_data;
                    cap_z[cap_n]   = m_data_z;
                    cap_sof[cap_n] = m_sof;
                    cap_eol[cap_n] = m_eol;
                end
                cap_n++;
            end
            if (frame_done) done_n++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input int kind, input int n, input bit rnd);
        int idx = 0;
        int budget = 0;
        bit took;
        while (idx < n) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = pix(kind, idx % N);
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                budget = 0;
            end else begin
                budget++;
                if (budget > 200) begin
                    check("input_accept_timeout", idx, n);
                    break;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int c = 0;
        while (done_n < target && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("frame_done_pulses", done_n, target);
    endtask

    initial begin
        tbl[0] = '{kind: 0, stall: 1'b0, exp_rep: {12{8'd7}}, exp_zero: '0, chk_zero: 1'b0};
        tbl[1] = '{kind: 1, stall: 1'b0, exp_rep: '0, exp_zero: '0, chk_zero: 1'b1};
        tbl[2] = '{kind: 2, stall: 1'b0,
                   exp_rep:  {8'd10, 8'd9, 8'd8, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1},
                   exp_zero: {8'd0, 8'd6, 8'd5, 8'd0, 8'd3, 8'd6, 8'd5, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0},
                   chk_zero: 1'b1};
        tbl[3] = tbl[2];
        tbl[3].stall = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_sof", int'(m_sof), 0);
        check("rst_m_eol", int'(m_eol), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_s_ready", int'(s_ready), 1);

        for (int v = 0; v < 4; v++) begin
            cap_n   = 0;
            done_n  = 0;
            bp_mode = tbl[v].stall;
            send(tbl[v].kind, N, tbl[v].stall);
            wait_done(1);
            bp_mode = 1'b0;
            check($sformatf("v%0d_out_count", v), cap_n, N);
            for (int i = 0; i < N; i++) begin
                check($sformatf("v%0d_data[%0d]", v, i), int'(cap_d[i]), int'(tbl[v].exp_rep[i]));
                if (tbl[v].chk_zero)
                    check($sformatf("v%0d_zero_data[%0d]", v, i), int'(cap_z[i]), int'(tbl[v].exp_zero[i]));
                check($sformatf("v%0d_sof[%0d]", v, i), int'(cap_sof[i]), (i == 0) ? 1 : 0);
                check($sformatf("v%0d_eol[%0d]", v, i), int'(cap_eol[i]), (i % W == W - 1) ? 1 : 0);
            end
        end

        // Mid-frame reset after five inputs, then a constant-9 frame
        cap_n  = 0;
        done_n = 0;
        send(2, 5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_s_ready", int'(s_ready), 0);
        check("midrst_m_valid", int'(m_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cap_n  = 0;
        done_n = 0;
        send(3, N, 1'b0);
        wait_done(1);
        check("midrst_out_count", cap_n, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("midrst_data[%0d]", i), int'(cap_d[i]), 9);
            check($sformatf("midrst_sof[%0d]", i), int'(cap_sof[i]), (i == 0) ? 1 : 0);
        end

        // Two ramp frames back to back
        cap_n  = 0;
        done_n = 0;
        send(2, 2 * N, 1'b0);
        wait_done(2);
        check("b2b_out_count", cap_n, 2 * N);
        for (int i = 0; i < 2 * N; i++) begin
            check($sformatf("b2b_data[%0d]", i), int'(cap_d[i]), int'(tbl[2].exp_rep[i % N]));
            check($sformatf("b2b_sof[%0d]", i), int'(cap_sof[i]), (i % N == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/streaming_median3x3.md
STREAMING_MEDIAN3X3 -- requirements
Module: streaming_median3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 554, pixels per line.
REQ-003 SHALL have parameter IMG_H, default 430, lines per frame.
REQ-004 SHALL have parameter BORDER_MODE, default 0, out-of-image neighbours: 0 = replicate nearest edge pixel, 1 = constant zero.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port s_valid, input, 1, input pixel valid.
REQ-008 SHALL have port s_ready, output, 1, input pixel accepted when s_valid && s_ready.
REQ-009 SHALL have port s_data, input, DATA_W, input pixel in raster order (line by line, left to right).
REQ-010 SHALL have port m_valid, output, 1, output pixel valid.
REQ-011 SHALL have port m_ready, input, 1, downstream accepts when m_valid && m_ready.
REQ-012 SHALL have port m_data, output, DATA_W, filtered pixel.
REQ-013 SHALL have port m_sof, output, 1, marks output pixel (0,0).
REQ-014 SHALL have port m_eol, output, 1, marks the last pixel of each output line.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse after the last output pixel is accepted.

Function
REQ-016 SHALL output, per pixel (r,c), the true median of its 9-pixel 3x3 neighbourhood (sorting network), not a median of row medians.
REQ-017 SHALL fill out-of-image neighbours per BORDER_MODE, for all 4 corners and 4 edges.
REQ-018 SHALL store the two previous lines in two IMG_W-deep line buffers plus a 3x3 window register.
REQ-019 SHALL emit output (r,c) only after input (r+1,c+1) is accepted, or during flush when that input does not exist.
REQ-020 SHALL use an FSM with states FILL, RUN, FLUSH and DONE:
  - FILL: initial buffering of the first line and first pixel; no output.
  - RUN: one output per accepted input.
  - FLUSH: after the final input, IMG_W+1 internal virtual pixels, s_ready=0.
  - DONE: frame_done pulse, then back to FILL.
REQ-021 SHALL deliver exactly IMG_W*IMG_H outputs per frame, in raster order.
REQ-022 SHALL use a median datapath with fixed latency of 3 enabled cycles; the pipeline advances only when its output slot is empty or accepted.
REQ-023 SHALL hold m_data, m_sof and m_eol stable while m_valid && !m_ready.
REQ-024 SHALL drive s_ready = 0 in FLUSH and DONE and whenever the pipeline is stalled; s_ready SHALL NOT depend combinationally on s_valid.
REQ-025 SHALL ignore s_data when s_valid is low, with no state advance.
REQ-026 SHALL wrap the column counter at IMG_W-1 and the row counter at IMG_H-1 back to 0; counters SHALL be $clog2-sized.
REQ-027 SHALL treat comparisons as unsigned DATA_W-bit.

Reset
REQ-028 SHALL, on rst asserted at any time including mid-frame, immediately clear s_ready, m_valid, m_data, m_sof, m_eol, frame_done, the counters and the pipeline valids to 0, and set the FSM to FILL.
REQ-029 SHALL leave line buffer contents unreset; stale data SHALL never reach the output.
REQ-030 SHALL start a new frame at pixel (0,0) on the first accepted pixel after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding and the BORDER_MODE constants in shared package median_pkg.
REQ-032 SHALL implement the 9-input pipelined median as sub-module median9_sort, parametrised by DATA_W.

Verification (IMG_W=4, IMG_H=3, DATA_W=8 unless noted)
REQ-033 SHALL check constant frame: all inputs 7 -> 12 outputs, all 7; m_sof on 1st output; m_eol on outputs 4, 8 and 12; one frame_done pulse.
REQ-034 SHALL check impulse: input 255 at (1,1), all others 0 -> all 12 outputs 0.
REQ-035 SHALL check replicate corner: input value r*4+c -> output (0,0)=1 and output (2,3)=10; with BORDER_MODE=1, output (0,0)=0.
REQ-036 SHALL check backpressure: random m_ready at 50% and random s_valid -> output sequence identical to the no-stall run, no lost or duplicated pixels.
REQ-037 SHALL check mid-frame reset: rst after 5 inputs, then a full constant-9 frame -> exactly 12 outputs, all 9, with m_sof on the first.
REQ-038 SHALL check back-to-back frames: two frames with no gap -> 24 outputs and two frame_done pulses, with m_sof on outputs 1 and 13.
